// File: rtl/pc_sequencer_if.sv
// Fetch / execute / status bundle between the lvm-16 PC sequencer and its neighbours.
// The master side is the sequencer; the slave side is memory, decode/execute and the jump-condition unit.
interface pc_sequencer_if;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_data;
    logic [15:0] instr;
    logic        instr_valid;
    logic        exec_done;
    logic        jmp;
    logic        incr;
    logic [15:0] jmp_target;
    logic        halt;
    logic [15:0] pc;
    logic [15:0] retired;
    logic        halted;
    logic        fault;

    modport master (
        output imem_req, imem_addr, instr, instr_valid, pc, retired, halted, fault,
        input  imem_ack, imem_data, exec_done, jmp, incr, jmp_target, halt
    );

    modport slave (
        input  imem_req, imem_addr, instr, instr_valid, pc, retired, halted, fault,
        output imem_ack, imem_data, exec_done, jmp, incr, jmp_target, halt
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter and fetch/branch sequencer for the lvm-16 core.
// Latency: 2 cycles/instruction with zero-wait ack and immediate exec_done.
// Backpressure: imem_req is held until imem_ack; the fetched word is held until exec_done.
module pc_sequencer #(
    parameter logic [15:0] RESET_PC      = 16'h0000,
    parameter logic [15:0] PC_STEP       = 16'd1,
    parameter int unsigned FETCH_TIMEOUT = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    pc_sequencer_if.master        bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_HALT  = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    state_t      state_q;
    logic [15:0] pc_q;
    logic [15:0] instr_q;
    logic [15:0] retired_q;
    logic [31:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            instr_q   <= 16'h0000;
            retired_q <= 16'h0000;
            cnt_q     <= 32'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_q <= S_FETCH;
                end
                S_FETCH: begin
                    if (bus.imem_ack) begin
                        instr_q <= bus.imem_data;
                        cnt_q   <= 32'd0;
                        state_q <= S_EXEC;
                    end else if (FETCH_TIMEOUT != 0 && cnt_q == FETCH_TIMEOUT - 1) begin
                        state_q <= S_FAULT;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                S_EXEC: begin
                    // halt outranks the jmp/incr legality check so a halting word always retires
                    if (bus.exec_done) begin
                        if (bus.halt) begin
                            retired_q <= retired_q + 16'd1;
                            state_q   <= S_HALT;
                        end else if (bus.jmp == bus.incr) begin
                            state_q <= S_FAULT;
                        end else if (bus.jmp) begin
                            pc_q      <= bus.jmp_target;
                            retired_q <= retired_q + 16'd1;
                            state_q   <= S_FETCH;
                        end else begin
                            pc_q      <= pc_q + PC_STEP;
                            retired_q <= retired_q + 16'd1;
                            state_q   <= S_FETCH;
                        end
                    end
                end
                default: begin
                    state_q <= state_q;
                end
            endcase
        end
    end

    assign bus.imem_req    = (state_q == S_FETCH);
    assign bus.imem_addr   = pc_q;
    assign bus.instr       = instr_q;
    assign bus.instr_valid = (state_q == S_EXEC);
    assign bus.pc          = pc_q;
    assign bus.retired     = retired_q;
    assign bus.halted      = (state_q == S_HALT);
    assign bus.fault       = (state_q == S_FAULT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios then random traffic, all checked against a
// transaction-level model of the fetch/execute rules.
module tb_pc_sequencer;

    localparam logic [15:0] RST_PC = 16'h0000;
    localparam int          TMO    = 8;

    localparam int M_IDLE  = 0;
    localparam int M_FETCH = 1;
    localparam int M_EXEC  = 2;
    localparam int M_HALT  = 3;
    localparam int M_FAULT = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    // reference model
    int m_mode;
    int m_pc;
    int m_instr;
    int m_retired;
    int m_wait;

    pc_sequencer_if bus ();

    pc_sequencer #(
        .RESET_PC      (RST_PC),
        .PC_STEP       (16'd1),
        .FETCH_TIMEOUT (TMO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_mode    = M_IDLE;
        m_pc      = int'(RST_PC);
        m_instr   = 0;
        m_retired = 0;
        m_wait    = 0;
    endtask

    // Predict the effect of the coming rising edge from the inputs currently driven.
    task automatic m_edge();
        case (m_mode)
            M_IDLE: begin
                m_mode = M_FETCH;
                m_wait = 0;
            end
            M_FETCH: begin
                if (bus.imem_ack) begin
                    m_instr = int'(bus.imem_data);
                    m_mode  = M_EXEC;
                end else begin
                    m_wait++;
                    if (TMO != 0 && m_wait >= TMO) m_mode = M_FAULT;
                end
            end
            M_EXEC: begin
                if (bus.exec_done) begin
                    if (bus.halt) begin
                        m_retired = (m_retired + 1) % 65536;
                        m_mode    = M_HALT;
                    end else if (bus.jmp == bus.incr) begin
                        m_mode = M_FAULT;
                    end else begin
                        m_pc      = bus.jmp ? int'(bus.jmp_target) : (m_pc + 1) % 65536;
                        m_retired = (m_retired + 1) % 65536;
                        m_mode    = M_FETCH;
                        m_wait    = 0;
                    end
                end
            end
            default: ;
        endcase
    endtask

    task automatic check_all();
        chk("imem_req",    bus.imem_req,    m_mode == M_FETCH);
        chk("imem_addr",   bus.imem_addr,   m_pc);
        chk("instr_valid", bus.instr_valid, m_mode == M_EXEC);
        chk("instr",       bus.instr,       m_instr);
        chk("pc",          bus.pc,          m_pc);
        chk("retired",     bus.retired,     m_retired);
        chk("halted",      bus.halted,      m_mode == M_HALT);
        chk("fault",       bus.fault,       m_mode == M_FAULT);
    endtask

    // Called at a falling edge: drive, predict, advance one cycle, compare.
    task automatic step(input logic ack, input logic [15:0] data, input logic done,
                        input logic j, input logic inc, input logic [15:0] tgt, input logic hlt);
        bus.imem_ack   = ack;
        bus.imem_data  = data;
        bus.exec_done  = done;
        bus.jmp        = j;
        bus.incr       = inc;
        bus.jmp_target = tgt;
        bus.halt       = hlt;
        m_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic idle_step();
        step(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    endtask

    // One instruction: zero-wait fetch, then exec_done with the given branch decision.
    task automatic instr(input logic [15:0] data, input logic j, input logic inc,
                         input logic [15:0] tgt, input logic hlt);
        step(1'b1, data, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        step(1'b0, 16'h0000, 1'b1, j, inc, tgt, hlt);
    endtask

    // Asynchronous reset asserted mid-cycle, released on a falling edge.
    task automatic apply_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_imem_req", bus.imem_req, 1'b0);
        chk("rst_pc",       bus.pc,       RST_PC);
        m_reset();
        @(negedge clk);
        check_all();
        bus.imem_ack  = 1'b0;
        bus.exec_done = 1'b0;
        rst_n         = 1'b1;
        idle_step();
    endtask

    logic [15:0] saved_ret;
    logic [15:0] saved_pc;

    initial begin
        rst_n          = 1'b0;
        bus.imem_ack   = 1'b0;
        bus.imem_data  = 16'h0000;
        bus.exec_done  = 1'b0;
        bus.jmp        = 1'b0;
        bus.incr       = 1'b0;
        bus.jmp_target = 16'h0000;
        bus.halt       = 1'b0;
        m_reset();
        #1;
        check_all();
        chk("reset_instr", bus.instr, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        idle_step();

        // sequential flow, zero-wait
        chk("t1_addr0", bus.imem_addr, 16'h0000);
        instr(16'h1111, 1'b0, 1'b1, 16'h0000, 1'b0);
        chk("t1_addr1", bus.imem_addr, 16'h0001);
        instr(16'h2222, 1'b0, 1'b1, 16'h0000, 1'b0);
        chk("t1_addr2", bus.imem_addr, 16'h0002);
        instr(16'h3333, 1'b0, 1'b1, 16'h0000, 1'b0);
        chk("t1_retired3", bus.retired, 16'd3);

        // delayed ack at 0005
        instr(16'h4444, 1'b0, 1'b1, 16'h0000, 1'b0);
        instr(16'h5555, 1'b0, 1'b1, 16'h0000, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("t2_req_held", bus.imem_req, 1'b1);
            chk("t2_addr_held", bus.imem_addr, 16'h0005);
            step(1'b0, 16'hDEAD, 1'b1, 1'b1, 1'b0, 16'h7777, 1'b0);
        end
        chk("t2_req_4th", bus.imem_req, 1'b1);
        step(1'b1, 16'hABCD, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
        chk("t2_instr", bus.instr, 16'hABCD);
        chk("t2_valid", bus.instr_valid, 1'b1);
        step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b0);
        chk("t2_exec_wait", bus.instr_valid, 1'b1);
        step(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0010, 1'b0);

        // branches and PC wrap
        chk("t3_addr10", bus.imem_addr, 16'h0010);
        instr(16'h6666, 1'b1, 1'b0, 16'h00A0, 1'b0);
        chk("t3_addrA0", bus.imem_addr, 16'h00A0);
        instr(16'h7777, 1'b1, 1'b0, 16'hFFFF, 1'b0);
        chk("t3_addrFFFF", bus.imem_addr, 16'hFFFF);
        instr(16'h8888, 1'b0, 1'b1, 16'h1234, 1'b0);
        chk("t3_wrap", bus.imem_addr, 16'h0000);

        // illegal jmp&incr
        saved_ret = bus.retired;
        instr(16'h9999, 1'b1, 1'b1, 16'h0040, 1'b0);
        chk("t5_fault", bus.fault, 1'b1);
        chk("t5_ret_same", bus.retired, saved_ret);
        idle_step();
        chk("t5_fault_sticky", bus.fault, 1'b1);

        // halt with jmp
        apply_reset();
        instr(16'h0101, 1'b0, 1'b1, 16'h0000, 1'b0);
        saved_pc  = bus.pc;
        saved_ret = bus.retired;
        instr(16'h0202, 1'b1, 1'b0, 16'h0300, 1'b1);
        chk("t5_halted", bus.halted, 1'b1);
        chk("t5_halt_pc", bus.pc, saved_pc);
        chk("t5_halt_ret", bus.retired, saved_ret + 16'd1);

        // fetch timeout
        apply_reset();
        for (int i = 0; i < TMO - 1; i++) idle_step();
        chk("t4_no_fault_7", bus.fault, 1'b0);
        idle_step();
        chk("t4_fault_8", bus.fault, 1'b1);
        chk("t4_req_low", bus.imem_req, 1'b0);
        chk("t4_pc", bus.pc, RST_PC);

        // reset during fetch wait
        apply_reset();
        instr(16'h0303, 1'b1, 1'b0, 16'h0420, 1'b0);
        idle_step();
        chk("t6_req_before", bus.imem_req, 1'b1);
        apply_reset();
        chk("t6_restart", bus.imem_req, 1'b1);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            if ((m_mode == M_HALT || m_mode == M_FAULT) && $urandom_range(0, 3) == 0) begin
                apply_reset();
            end else begin
                int r;
                logic jj, ii;
                r = $urandom_range(0, 19);
                if (r == 0)      begin jj = 1'b1; ii = 1'b1; end
                else if (r == 1) begin jj = 1'b0; ii = 1'b0; end
                else if (r < 10) begin jj = 1'b1; ii = 1'b0; end
                else             begin jj = 1'b0; ii = 1'b1; end
                step($urandom_range(0, 9) < 6, 16'($urandom), $urandom_range(0, 9) < 6,
                     jj, ii, 16'($urandom), $urandom_range(0, 24) == 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
